// File: rtl/lc4_regfile_sb.sv
// LC4 register file with a per-register busy scoreboard, write-to-read
// forwarding and a registered count of in-flight producers.
module lc4_regfile_sb #(
    parameter int n      = 16,
    parameter int r      = 3,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic [r-1:0] i_rs,
    output logic [n-1:0] o_rs_data,
    output logic         o_rs_busy,
    input  logic [r-1:0] i_rt,
    output logic [n-1:0] o_rt_data,
    output logic         o_rt_busy,
    input  logic [r-1:0] i_rd,
    input  logic [n-1:0] i_wdata,
    input  logic         i_rd_we,
    input  logic         i_alloc,
    input  logic [r-1:0] i_alloc_rd,
    input  logic         i_flush,
    output logic [r:0]   o_busy_count,
    output logic         o_stall
);

    localparam int NREG = 1 << r;

    logic [n-1:0]    regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [r:0]      busy_count;
    logic [r:0]      count_nxt;
    logic            rs_hit;
    logic            rt_hit;
    logic            alloc_clear;

    // Priority: write clears, allocate sets, flush clears everything.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        busy_nxt = busy;
        if (gwe) begin
            if (i_rd_we) busy_nxt[i_rd] = 1'b0;
            if (i_alloc) busy_nxt[i_alloc_rd] = 1'b1;
            if (i_flush) busy_nxt = '0;
        end
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            count_nxt = count_nxt + (r+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register array is reset too, since reads must return 0 after reset.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else if (gwe) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (i_rd_we) regs[i_rd] <= i_wdata;
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    always_comb begin
        rs_hit = (BYPASS != 0) && gwe && i_rd_we && (i_rd == i_rs);
        rt_hit = (BYPASS != 0) && gwe && i_rd_we && (i_rd == i_rt);

        o_rs_data = rs_hit ? i_wdata : regs[i_rs];
        o_rt_data = rt_hit ? i_wdata : regs[i_rt];
        o_rs_busy = busy[i_rs] & ~rs_hit;
        o_rt_busy = busy[i_rt] & ~rt_hit;

        // A WAW hazard is only real if the old producer is not retiring this edge.
        alloc_clear = gwe && (i_flush || (i_rd_we && (i_rd == i_alloc_rd)));
        o_stall     = o_rs_busy | o_rt_busy | (i_alloc & busy[i_alloc_rd] & ~alloc_clear);
    end

    assign o_busy_count = busy_count;

endmodule

// File: tb/tb_lc4_regfile_sb.sv
// Scoreboard bench for lc4_regfile_sb: one forwarding and one non-forwarding
// instance share stimulus; a behavioural model predicts every output.
module tb_lc4_regfile_sb;

    localparam int N    = 16;
    localparam int R    = 3;
    localparam int NREG = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, gwe, rd_we, alloc, flush;
    logic [R-1:0] rs, rt, rd, alloc_rd;
    logic [N-1:0] wdata;

    logic [N-1:0] rs_data, rt_data, rs_data_nb, rt_data_nb;
    logic         rs_busy, rt_busy, rs_busy_nb, rt_busy_nb, stall, stall_nb;
    logic [R:0]   count, count_nb;

    lc4_regfile_sb #(.n(N), .r(R), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_rs(rs), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
        .i_rt(rt), .o_rt_data(rt_data), .o_rt_busy(rt_busy),
        .i_rd(rd), .i_wdata(wdata), .i_rd_we(rd_we),
        .i_alloc(alloc), .i_alloc_rd(alloc_rd), .i_flush(flush),
        .o_busy_count(count), .o_stall(stall)
    );

    lc4_regfile_sb #(.n(N), .r(R), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_rs(rs), .o_rs_data(rs_data_nb), .o_rs_busy(rs_busy_nb),
        .i_rt(rt), .o_rt_data(rt_data_nb), .o_rt_busy(rt_busy_nb),
        .i_rd(rd), .i_wdata(wdata), .i_rd_we(rd_we),
        .i_alloc(alloc), .i_alloc_rd(alloc_rd), .i_flush(flush),
        .o_busy_count(count_nb), .o_stall(stall_nb)
    );

    typedef struct {
        logic [N-1:0] rs_data, rt_data, rs_data_nb, rt_data_nb;
        logic         rs_busy, rt_busy, rs_busy_nb, rt_busy_nb, stall, stall_nb;
        logic [R:0]   count;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] m_reg [NREG];
    bit           m_busy[NREG];
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Applies the architectural effect of the inputs held across the edge just taken.
    task automatic model_step();
        if (!rst) begin
            model_clear();
        end else if (gwe) begin
            if (rd_we) begin
                m_reg[rd]  = wdata;
                m_busy[rd] = 1'b0;
            end
            if (alloc) m_busy[alloc_rd] = 1'b1;
            if (flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end
    endtask

    task automatic expect_now();
        exp_t e;
        bit   hit_s, hit_t, waw;
        int   c;
        if (!rst) model_clear();
        hit_s = gwe && rd_we && (rd == rs);
        hit_t = gwe && rd_we && (rd == rt);
        e.rs_data    = hit_s ? wdata : m_reg[rs];
        e.rt_data    = hit_t ? wdata : m_reg[rt];
        e.rs_busy    = m_busy[rs] && !hit_s;
        e.rt_busy    = m_busy[rt] && !hit_t;
        e.rs_data_nb = m_reg[rs];
        e.rt_data_nb = m_reg[rt];
        e.rs_busy_nb = m_busy[rs];
        e.rt_busy_nb = m_busy[rt];
        waw = alloc && m_busy[alloc_rd] && !(gwe && (flush || (rd_we && rd == alloc_rd)));
        e.stall    = e.rs_busy || e.rt_busy || waw;
        e.stall_nb = e.rs_busy_nb || e.rt_busy_nb || waw;
        c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        e.count = (R+1)'(c);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst_v, input bit g, input bit we, input logic [R-1:0] rd_v,
                         input logic [N-1:0] wd, input bit al, input logic [R-1:0] ard,
                         input bit fl, input logic [R-1:0] rs_v, input logic [R-1:0] rt_v);
        @(posedge clk);
        #1;
        model_step();
        rst = rst_v; gwe = g; rd_we = we; rd = rd_v; wdata = wd;
        alloc = al; alloc_rd = ard; flush = fl; rs = rs_v; rt = rt_v;
        expect_now();
    endtask

    task automatic idle(input logic [R-1:0] rs_v, input logic [R-1:0] rt_v);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, rs_v, rt_v);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rs_data",    32'(rs_data),    32'(e.rs_data));
                check("rt_data",    32'(rt_data),    32'(e.rt_data));
                check("rs_busy",    32'(rs_busy),    32'(e.rs_busy));
                check("rt_busy",    32'(rt_busy),    32'(e.rt_busy));
                check("stall",      32'(stall),      32'(e.stall));
                check("busy_count", 32'(count),      32'(e.count));
                check("rs_data_nb", 32'(rs_data_nb), 32'(e.rs_data_nb));
                check("rt_data_nb", 32'(rt_data_nb), 32'(e.rt_data_nb));
                check("rs_busy_nb", 32'(rs_busy_nb), 32'(e.rs_busy_nb));
                check("rt_busy_nb", 32'(rt_busy_nb), 32'(e.rt_busy_nb));
                check("stall_nb",   32'(stall_nb),   32'(e.stall_nb));
                check("count_nb",   32'(count_nb),   32'(e.count));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; gwe = 1'b0; rd_we = 1'b0; alloc = 1'b0; flush = 1'b0;
        rs = '0; rt = '0; rd = '0; alloc_rd = '0; wdata = '0;
        model_clear();

        // Reset, then sweep every register on both ports.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < NREG; i++) idle(3'(i), 3'(7 - i));

        // Same-cycle forwarding, then the registered value.
        drive(1'b1, 1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd3, 3'd0);
        idle(3'd3, 3'd0);

        // Allocate R5, observe it busy, retire it with a bypassed write.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0, 3'd0);
        idle(3'd0, 3'd5);
        drive(1'b1, 1'b1, 1'b1, 3'd5, 16'h0042, 1'b0, 3'd0, 1'b0, 3'd0, 3'd5);
        idle(3'd0, 3'd5);

        // Write and allocate R2 together, then a WAW re-allocate.
        drive(1'b1, 1'b1, 1'b1, 3'd2, 16'h1234, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0);
        idle(3'd2, 3'd0);

        // Fill the scoreboard, then flush against a concurrent allocate.
        for (int i = 0; i < NREG; i++)
            drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'd1, 3'd6);
        idle(3'd3, 3'd5);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd3, 3'd2);
        idle(3'd3, 3'd2);

        // Global write enable low: nothing happens, no forwarding.
        drive(1'b1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 1'b0, 3'd1, 3'd1);
        idle(3'd1, 3'd3);

        // Build some state, then assert reset between edges.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd3, 3'd4);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd2);
        idle(3'd3, 3'd4);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  16'($urandom),
                  ($urandom_range(0, 9) < 4),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end
        idle(3'd0, 3'd1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
